// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, frame/bit-period widths
// and the bit-period clamp used when a frame is started.
package uart_pkg;

  localparam int UART_DATA_W = 8;
  localparam int UART_CPB_W  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  // A programmed bit period of zero would stall the bit counter; run it as one cycle.
  function automatic logic [UART_CPB_W-1:0] clamp_cpb(input logic [UART_CPB_W-1:0] cpb);
    return (cpb == '0) ? UART_CPB_W'(1) : cpb;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous transmit FIFO: single clock, power-of-two depth, occupancy counter.
// Pushes while full and pops while empty are ignored; reset flushes the contents.
module uart_tx_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [DATA_W-1:0]          wdata_i,
  output logic [DATA_W-1:0]          rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     level_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q,  level_d;
  logic              do_push, do_pop;

  assign full_o  = (level_q == LVL_W'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointer and occupancy next-state; simultaneous push and pop leave the level alone.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // Control state; reset wins over a coincident push so that byte is dropped.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage array; contents are only meaningful between the pointers, so no reset.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/uart_tx_prog.sv
// Programmable-baud 8N1 UART transmitter. Bytes queue in a small FIFO and are
// framed back-to-back; the bit period is captured from clks_per_bit_i at the
// start of each frame so mid-frame changes only affect later frames.
module uart_tx_prog
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int DATA_W     = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [UART_CPB_W-1:0]         clks_per_bit_i,
  input  logic [DATA_W-1:0]             tx_data_i,
  input  logic                          tx_valid_i,
  output logic                          tx_ready_o,
  output logic                          tx_o,
  output logic                          tx_busy_o,
  output logic                          tx_done_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  tx_state_e             state_q, state_d;
  logic [UART_CPB_W-1:0] cnt_q, cnt_d;
  logic [UART_CPB_W-1:0] cpb_q, cpb_d;
  logic [2:0]            bit_idx_q, bit_idx_d;
  logic [DATA_W-1:0]     shift_q, shift_d;
  logic                  tx_q, tx_d;
  logic                  done_q, done_d;

  logic [DATA_W-1:0]     fifo_rdata;
  logic                  fifo_full, fifo_empty;
  logic [LVL_W-1:0]      fifo_level;
  logic                  pop, load, bit_last;

  uart_tx_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (tx_valid_i),
    .pop_i   (pop),
    .wdata_i (tx_data_i),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  assign tx_ready_o   = !fifo_full;
  assign fifo_level_o = fifo_level;
  assign tx_busy_o    = (state_q != IDLE);
  assign tx_o         = tx_q;
  assign tx_done_o    = done_q;

  // Last cycle of the current bit period.
  assign bit_last = (cnt_q == cpb_q - UART_CPB_W'(1));

  // Control registers; line idles high after reset and any partial frame is dropped.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      tx_q      <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      tx_q      <= tx_d;
      done_q    <= done_d;
    end
  end

  // Frame datapath registers; only read while a frame is in flight.
  always_ff @(posedge clk_i) begin
    shift_q <= shift_d;
    cpb_q   <= cpb_d;
  end

  // Next-state: bit timing, bit sequencing and FIFO pop at frame boundaries.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    cpb_d     = cpb_q;
    load      = 1'b0;
    case (state_q)
      IDLE: begin
        load = !fifo_empty;
      end
      START: begin
        if (bit_last) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = DATA;
        end else begin
          cnt_d = cnt_q + UART_CPB_W'(1);
        end
      end
      DATA: begin
        if (bit_last) begin
          cnt_d   = '0;
          shift_d = shift_q >> 1;
          if (bit_idx_q == 3'(UART_DATA_W - 1)) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + UART_CPB_W'(1);
        end
      end
      STOP: begin
        if (bit_last) begin
          cnt_d = '0;
          if (!fifo_empty) load = 1'b1;
          else             state_d = IDLE;
        end else begin
          cnt_d = cnt_q + UART_CPB_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    if (load) begin
      state_d = START;
      cnt_d   = '0;
      shift_d = fifo_rdata;
      cpb_d   = clamp_cpb(clks_per_bit_i);
    end
    pop = load;
  end

  // Outputs registered from next state so the line changes on the same edge as the state.
  always_comb begin
    done_d = (state_q == STOP) && bit_last;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

endmodule
